// File: rtl/fir_tdm_param.sv
// Time-multiplexed direct-form FIR: one shared registered multiplier walks all taps,
// then the accumulator is rounded, optionally saturated and presented on filtout.
module fir_tdm_param #(
  parameter int TAPS      = 4,
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int OUT_SHIFT = 0,
  parameter int SATURATE  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [DATA_W-1:0]   datain,
  input  logic                       datavalid,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic signed [DATA_W-1:0]   filtout,
  output logic                       done,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW     = $clog2(TAPS);
  localparam int PW     = DATA_W + COEF_W;
  localparam int ACC_W  = PW + AW;
  localparam int RW     = ACC_W + 1;
  localparam int RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND_C =
    (OUT_SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RND_SH) : {RW{1'b0}};
  localparam logic signed [RW-1:0] MAX_C = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_C = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [AW-1:0]        LAST_IDX = AW'(TAPS - 1);
  localparam logic [AW:0]          TAPS_C   = (AW+1)'(TAPS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  // The extra headroom bit keeps the rounding add from wrapping before the shift.
  function automatic logic signed [DATA_W-1:0] shape_out(input logic signed [ACC_W-1:0] acc);
    logic signed [RW-1:0]     r;
    logic signed [DATA_W-1:0] y;
    r = $signed({acc[ACC_W-1], acc}) + RND_C;
    r = r >>> OUT_SHIFT;
    if (SATURATE != 0) begin
      if (r > MAX_C) begin
        y = MAX_C[DATA_W-1:0];
      end else if (r < MIN_C) begin
        y = MIN_C[DATA_W-1:0];
      end else begin
        y = r[DATA_W-1:0];
      end
    end else begin
      y = r[DATA_W-1:0];
    end
    return y;
  endfunction

  state_e                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q    [TAPS];
  logic signed [DATA_W-1:0]  x_d    [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [COEF_W-1:0]  coef_d [TAPS];
  logic [AW-1:0]             idx_q, idx_d;
  logic signed [PW-1:0]      prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]  filt_q, filt_d;
  logic                      done_q, done_d;
  logic                      ovr_q, ovr_d;

  logic signed [PW-1:0]      mul_a_s, mul_b_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic                      coef_ok_s;

  assign mul_a_s    = {{COEF_W{x_q[idx_q][DATA_W-1]}}, x_q[idx_q]};
  assign mul_b_s    = {{DATA_W{coef_q[idx_q][COEF_W-1]}}, coef_q[idx_q]};
  assign prod_ext_s = {{AW{prod_q[PW-1]}}, prod_q};
  assign coef_ok_s  = (state_q == S_IDLE) && ({1'b0, coef_addr} < TAPS_C);

  assign busy    = (state_q != S_IDLE);
  assign filtout = filt_q;
  assign done    = done_q;
  assign overrun = ovr_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (datavalid) begin
          state_d = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_MAC;
        end
      end
      S_DRAIN: state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: delay line, coefficients, MAC pipeline and outputs.
  always_comb begin
    x_d    = x_q;
    coef_d = coef_q;
    idx_d  = idx_q;
    prod_d = prod_q;
    acc_d  = acc_q;
    filt_d = filt_q;
    done_d = 1'b0;
    ovr_d  = 1'b0;

    if (coef_we && coef_ok_s) begin
      coef_d[coef_addr] = coef_wdata;
    end else begin
      coef_d = coef_q;
    end

    case (state_q)
      S_IDLE: begin
        if (datavalid) begin
          x_d[0] = datain;
          for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d = {ACC_W{1'b0}};
          idx_d = {AW{1'b0}};
        end else begin
          idx_d = idx_q;
        end
      end
      S_MAC: begin
        prod_d = mul_a_s * mul_b_s;
        // The product register is one tap behind, so the first MAC edge adds nothing.
        if (idx_q != {AW{1'b0}}) begin
          acc_d = acc_q + prod_ext_s;
        end else begin
          acc_d = acc_q;
        end
        if (idx_q == LAST_IDX) begin
          idx_d = {AW{1'b0}};
        end else begin
          idx_d = idx_q + AW'(1);
        end
        ovr_d = datavalid;
      end
      S_DRAIN: begin
        acc_d = acc_q + prod_ext_s;
        ovr_d = datavalid;
      end
      S_OUT: begin
        filt_d = shape_out(acc_q);
        done_d = 1'b1;
        ovr_d  = datavalid;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
      idx_q  <= '0;
      prod_q <= '0;
      acc_q  <= '0;
      filt_q <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      coef_q <= coef_d;
      idx_q  <= idx_d;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      filt_q <= filt_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule

// File: tb/tb_fir_tdm_param.sv
// Bench for fir_tdm_param: three configurations (saturate, wrap, round+saturate) share one
// stimulus stream and are checked against fixed vectors and an arithmetic reference model.
module tb_fir_tdm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic signed [7:0] datain;
  logic              datavalid;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic signed [7:0] coef_wdata;
  logic signed [7:0] f0, f1, f2;
  logic              d0, d1, d2, b0, b1, b2, o0, o1, o2;

  fir_tdm_param #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_SHIFT(0), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .datain(datain), .datavalid(datavalid), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .filtout(f0), .done(d0), .busy(b0),
    .overrun(o0));

  fir_tdm_param #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_SHIFT(0), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .datain(datain), .datavalid(datavalid), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .filtout(f1), .done(d1), .busy(b1),
    .overrun(o1));

  fir_tdm_param #(.TAPS(4), .DATA_W(8), .COEF_W(8), .OUT_SHIFT(7), .SATURATE(1)) u_rnd (
    .clk(clk), .rst_n(rst_n), .datain(datain), .datavalid(datavalid), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_wdata(coef_wdata), .filtout(f2), .done(d2), .busy(b2),
    .overrun(o2));

  int checks   = 0;
  int failures = 0;
  int m_x [4];
  int m_c [4];

  typedef struct {
    logic [31:0] coefs;    // coef[k] in byte k
    logic [31:0] samples;  // byte j is the j-th sample pushed
    int          e_sat;
    int          e_wrap;
    int          e_rnd;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum of products, then round/shift and clamp or wrap with plain integer math.
  function automatic longint m_acc();
    longint s;
    s = 0;
    for (int k = 0; k < 4; k++) s += longint'(m_x[k]) * longint'(m_c[k]);
    return s;
  endfunction

  function automatic int m_shape(input longint acc, input int sh, input bit sat);
    longint            r;
    logic signed [7:0] lo;
    if (sh > 0) r = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    else        r = acc;
    if (sat) begin
      if (r > 127)       r = 127;
      else if (r < -128) r = -128;
    end
    lo = r[7:0];
    return int'(lo);
  endfunction

  function automatic int rnd8();
    logic signed [7:0] v;
    v = 8'($urandom_range(0, 255));
    return int'(v);
  endfunction

  task automatic m_push(input int d);
    for (int k = 3; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = d;
  endtask

  task automatic check_model(input string tag);
    longint a;
    a = m_acc();
    chk({tag, "/sat"},  int'(f0), m_shape(a, 0, 1'b1));
    chk({tag, "/wrap"}, int'(f1), m_shape(a, 0, 1'b0));
    chk({tag, "/rnd"},  int'(f2), m_shape(a, 7, 1'b1));
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = a[1:0];
    coef_wdata = v[7:0];
    step();
    coef_we    = 1'b0;
    m_c[a]     = v;
  endtask

  // Caller is in an idle or done cycle; returns in the done cycle.
  task automatic run_sample(input int d, input bit we, input int a, input int c);
    int lat;
    datain     = d[7:0];
    datavalid  = 1'b1;
    coef_we    = we;
    coef_addr  = a[1:0];
    coef_wdata = c[7:0];
    if (we) m_c[a] = c;
    m_push(d);
    step();
    datavalid = 1'b0;
    coef_we   = 1'b0;
    lat = 0;
    while (d0 !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 6);
    chk("busy_in_done", int'(b0 | b1 | b2), 0);
    chk("done_all", int'(d1 & d2), 1);
  endtask

  initial begin
    int lat;
    int exp_imp [5];
    logic signed [7:0] sb;

    tbl[0] = '{32'h7F7F7F7F, 32'h7F7F7F7F,  127,   4,  127};
    tbl[1] = '{32'h7F7F7F7F, 32'h80808080, -128,   0, -128};
    tbl[2] = '{32'h00000040, 32'h03000000,  127, -64,    2};
    tbl[3] = '{32'h00000040, 32'hFD000000, -128,  64,   -1};
    tbl[4] = '{32'h00000040, 32'h01000000,   64,  64,    1};
    tbl[5] = '{32'h04030201, 32'h281E140A,  127, -56,    2};
    tbl[6] = '{32'h02FE01FF, 32'hF807FA05,   37,  37,    0};
    exp_imp = '{1, 2, 3, 4, 0};

    rst_n = 1'b0; datain = '0; datavalid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    for (int k = 0; k < 4; k++) begin m_x[k] = 0; m_c[k] = 0; end
    step(); step();
    chk("reset_filtout", int'(f0 | f1 | f2), 0);
    chk("reset_done", int'(d0 | d1 | d2), 0);
    chk("reset_busy", int'(b0 | b1 | b2), 0);
    chk("reset_overrun", int'(o0 | o1 | o2), 0);
    rst_n = 1'b1;
    step();

    // Impulse response, issued back to back in each done cycle.
    for (int k = 0; k < 4; k++) write_coef(k, k + 1);
    for (int i = 0; i < 5; i++) begin
      run_sample((i == 0) ? 1 : 0, 1'b0, 0, 0);
      chk($sformatf("impulse%0d", i), int'(f0), exp_imp[i]);
    end
    step();
    chk("done_width", int'(d0), 0);
    chk("filtout_hold", int'(f0), 0);

    // Fixed vectors.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++) begin
        sb = tbl[i].coefs[8*k +: 8];
        write_coef(k, int'(sb));
      end
      for (int j = 0; j < 4; j++) begin
        sb = tbl[i].samples[8*j +: 8];
        run_sample(int'(sb), 1'b0, 0, 0);
      end
      chk($sformatf("tbl%0d/sat", i),  int'(f0), tbl[i].e_sat);
      chk($sformatf("tbl%0d/wrap", i), int'(f1), tbl[i].e_wrap);
      chk($sformatf("tbl%0d/rnd", i),  int'(f2), tbl[i].e_rnd);
    end

    // Dropped sample and ignored coefficient write while busy.
    for (int k = 0; k < 4; k++) write_coef(k, 3 * k - 5);
    datain = 8'sd20; datavalid = 1'b1; m_push(20);
    step();
    datavalid = 1'b0;
    step();
    datain = 8'sd99; datavalid = 1'b1; coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 8'sd55;
    step();
    datavalid = 1'b0; coef_we = 1'b0;
    chk("overrun_pulse", int'(o0 & o1 & o2), 1);
    step();
    chk("overrun_width", int'(o0), 0);
    lat = 0;
    while (d0 !== 1'b1 && lat < 20) begin step(); lat++; end
    chk("overrun_done_lat", lat, 3);
    check_model("overrun_result");
    for (int j = 0; j < 3; j++) run_sample(0, 1'b0, 0, 0);
    run_sample(1, 1'b0, 0, 0);
    chk("coef0_readback", int'(f0), -5);
    check_model("readback");

    // Randomised samples with writes in idle and on the accept edge.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) write_coef($urandom_range(0, 3), rnd8());
      run_sample(rnd8(), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), rnd8());
      check_model($sformatf("rand%0d", it));
      if ($urandom_range(0, 3) == 0) step();
    end

    // Reset in the middle of MAC.
    datain = 8'sd50; datavalid = 1'b1;
    step();
    datavalid = 1'b0;
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_filtout", int'(f0 | f1 | f2), 0);
    chk("midrst_busy", int'(b0), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("midrst_no_done", int'(d0 | d1 | d2), 0);
    end
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin m_x[k] = 0; m_c[k] = 0; end
    run_sample(1, 1'b0, 0, 0);
    chk("post_reset_impulse", int'(f0), 0);
    check_model("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
